// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - 720p30 video timing generator: registered sync, de, coordinates, line/frame pulses
// Optional frame counter enabled by defining VTG_FRAME_CNT_EN.
module video_timing_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 1760,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int CNT_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             line_start,
  output logic             frame_start,
  output logic [15:0]      frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;

  logic h_last;
  logic de_d;
  logic hs_act;
  logic vs_act;
  logic ls_d;
  logic fs_d;

  // Decode the current counter state; registering it gives the fixed one-cycle latency.
  always_comb begin
    h_last = (h_cnt == H_LAST);
    de_d   = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    hs_act = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs_act = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
    ls_d   = (h_cnt == '0) && (v_cnt < V_ACT_C);
    fs_d   = (h_cnt == '0) && (v_cnt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      de          <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
    end else if (en) begin
      if (h_last) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
      pix_x       <= h_cnt;
      pix_y       <= v_cnt;
      de          <= de_d;
      line_start  <= ls_d;
      frame_start <= fs_d;
      hsync       <= hs_act ? HS_POL : ~HS_POL;
      vsync       <= vs_act ? VS_POL : ~VS_POL;
    end else begin
      // Stalled: levels hold, but a pulse must not stretch across the stall.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;
  logic        first_seen;

  // The first frame after reset reads 0, so the first frame_start only arms the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt_q <= '0;
      first_seen  <= 1'b0;
    end else if (en && fs_d) begin
      first_seen <= 1'b1;
      if (first_seen) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
  assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - directed self-checking bench for video_timing_gen (default and small timings)
module tb_video_timing_gen;

`ifdef VTG_FRAME_CNT_EN
  localparam int FC_ON = 1;
`else
  localparam int FC_ON = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, en0, rst1, en1;
  logic        hs0, vs0, de0, ls0, fs0;
  logic        hs1, vs1, de1, ls1, fs1;
  logic [11:0] x0, y0, x1, y1;
  logic [15:0] fc0, fc1;

  int checks   = 0;
  int failures = 0;

  video_timing_gen d0 (
    .clk(clk), .rst(rst0), .en(en0), .hsync(hs0), .vsync(vs0), .de(de0),
    .pix_x(x0), .pix_y(y0), .line_start(ls0), .frame_start(fs0), .frame_cnt(fc0)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) d1 (
    .clk(clk), .rst(rst1), .en(en1), .hsync(hs1), .vsync(vs1), .de(de1),
    .pix_x(x1), .pix_y(y1), .line_start(ls1), .frame_start(fs1), .frame_cnt(fc1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int de_cnt, de_first, de_last, hs_cnt, hs_first, hs_last, ls_cnt, xbad;
    int n, hold_bad, pulse_bad;
    int vs_cnt, vs_bad, vs_first_x, fs_cnt, fs_pos0, fs_pos1, fc_at_fs;

    rst0 = 1'b1; en0 = 1'b0; rst1 = 1'b1; en1 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state on both instances
    check("rst_pix_x", x0, 0);
    check("rst_pix_y", y0, 0);
    check("rst_de", de0, 0);
    check("rst_hsync", hs0, 0);
    check("rst_vsync", vs0, 0);
    check("rst_line_start", ls0, 0);
    check("rst_frame_start", fs0, 0);
    check("rst_frame_cnt", fc0, 0);
    check("rst_small_de", de1, 0);

    // First enabled edge
    rst0 = 1'b0; en0 = 1'b1;
    @(negedge clk);
    check("first_de", de0, 1);
    check("first_frame_start", fs0, 1);
    check("first_line_start", ls0, 1);
    check("first_pix_x", x0, 0);
    check("first_pix_y", y0, 0);

    // One full default line
    de_cnt = 0; de_first = -1; de_last = -1;
    hs_cnt = 0; hs_first = -1; hs_last = -1;
    ls_cnt = 0; xbad = 0;
    for (int i = 0; i < 3300; i++) begin
      if (x0 != 12'(i) || y0 != 12'd0) xbad++;
      if (de0) begin
        de_cnt++;
        if (de_first < 0) de_first = i;
        de_last = i;
      end
      if (hs0) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      if (ls0) ls_cnt++;
      @(negedge clk);
    end
    check("line_pix_x_seq", xbad, 0);
    check("line_de_count", de_cnt, 1280);
    check("line_de_first", de_first, 0);
    check("line_de_last", de_last, 1279);
    check("line_hsync_count", hs_cnt, 40);
    check("line_hsync_first", hs_first, 3040);
    check("line_hsync_last", hs_last, 3079);
    check("line_ls_count", ls_cnt, 1);
    check("line2_line_start", ls0, 1);
    check("line2_pix_x", x0, 0);
    check("line2_pix_y", y0, 1);
    check("line2_frame_start", fs0, 0);

    // en stall at pix_x=100 on line 1
    n = 0;
    while (x0 != 12'd100 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check("wait_x100_timeout", (n < 4000) ? 1 : 0, 1);
    en0 = 1'b0;
    hold_bad = 0; pulse_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (x0 != 12'd100 || y0 != 12'd1 || de0 != 1'b1 || hs0 != 1'b0) hold_bad++;
      if (ls0 || fs0) pulse_bad++;
    end
    check("stall_hold", hold_bad, 0);
    check("stall_pulses", pulse_bad, 0);
    en0 = 1'b1;
    @(negedge clk);
    check("stall_resume_x", x0, 101);
    check("stall_resume_y", y0, 1);

    // Small timing: 14 x 7, start and a held frame_start pulse
    rst1 = 1'b0; en1 = 1'b1;
    @(negedge clk);
    check("small_first_fs", fs1, 1);
    check("small_first_x", x1, 0);
    en1 = 1'b0;
    @(negedge clk);
    check("small_stall_fs_clear", fs1, 0);
    check("small_stall_ls_clear", ls1, 0);
    check("small_stall_hold_de", de1, 1);
    check("small_stall_hold_x", x1, 0);
    en1 = 1'b1;
    @(negedge clk);
    check("small_resume_x", x1, 1);

    // 200 cycles from frame position 1: two full vsync lines, two frame_starts
    vs_cnt = 0; vs_bad = 0; vs_first_x = -1; fs_cnt = 0;
    fs_pos0 = -1; fs_pos1 = -1; fc_at_fs = -1;
    for (int p = 1; p <= 200; p++) begin
      if (vs1) begin
        vs_cnt++;
        if (y1 != 12'd5) vs_bad++;
        if (vs_first_x < 0) vs_first_x = int'(x1);
      end
      if (fs1) begin
        fs_cnt++;
        if (fs_pos0 < 0) begin
          fs_pos0 = p;
          fc_at_fs = int'(fc1);
        end else begin
          fs_pos1 = p;
        end
      end
      @(negedge clk);
    end
    check("small_vsync_count", vs_cnt, 28);
    check("small_vsync_row", vs_bad, 0);
    check("small_vsync_first_x", vs_first_x, 0);
    check("small_fs_count", fs_cnt, 2);
    check("small_fs_pos", fs_pos0, 98);
    check("small_fs_period", fs_pos1 - fs_pos0, 98);
    check("small_frame_cnt_2nd", fc_at_fs, FC_ON);
    check("small_frame_cnt_3rd", fc1, 2 * FC_ON);

    // Mid-frame reset with en still high
    n = 0;
    while (y1 != 12'd2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("wait_y2_timeout", (n < 200) ? 1 : 0, 1);
    rst1 = 1'b1;
    @(negedge clk);
    check("midrst_x", x1, 0);
    check("midrst_y", y1, 0);
    check("midrst_de", de1, 0);
    check("midrst_fs", fs1, 0);
    check("midrst_frame_cnt", fc1, 0);
    rst1 = 1'b0;
    @(negedge clk);
    check("restart_fs", fs1, 1);
    check("restart_de", de1, 1);
    check("restart_xy", {x1, y1}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
